// File: rtl/hazard_scoreboard_pkg.sv
// Shared instruction defines: RV32I instruction-ID constants, hazard slot layout and load-ID set.
// Pure declarations, no timing or flow control of its own.
package hazard_scoreboard_pkg;

  localparam int SLOT_AW    = 5;
  localparam int INSTR_ID_W = 6;

  typedef enum logic [INSTR_ID_W-1:0] {
    ID_NOP    = 6'd0,
    ID_LUI    = 6'd1,
    ID_AUIPC  = 6'd2,
    ID_JAL    = 6'd3,
    ID_JALR   = 6'd4,
    ID_BEQ    = 6'd5,
    ID_BNE    = 6'd6,
    ID_BLT    = 6'd7,
    ID_BGE    = 6'd8,
    ID_BLTU   = 6'd9,
    ID_BGEU   = 6'd10,
    ID_LB     = 6'd11,
    ID_LH     = 6'd12,
    ID_LW     = 6'd13,
    ID_LBU    = 6'd14,
    ID_LHU    = 6'd15,
    ID_SB     = 6'd16,
    ID_SH     = 6'd17,
    ID_SW     = 6'd18,
    ID_ADDI   = 6'd19,
    ID_SLTI   = 6'd20,
    ID_SLTIU  = 6'd21,
    ID_XORI   = 6'd22,
    ID_ORI    = 6'd23,
    ID_ANDI   = 6'd24,
    ID_SLLI   = 6'd25,
    ID_SRLI   = 6'd26,
    ID_SRAI   = 6'd27,
    ID_ADD    = 6'd28,
    ID_SUB    = 6'd29,
    ID_SLL    = 6'd30,
    ID_SLT    = 6'd31,
    ID_SLTU   = 6'd32,
    ID_XOR    = 6'd33,
    ID_SRL    = 6'd34,
    ID_SRA    = 6'd35,
    ID_OR     = 6'd36,
    ID_AND    = 6'd37,
    ID_FENCE  = 6'd38,
    ID_ECALL  = 6'd39,
    ID_EBREAK = 6'd40
  } instr_id_e;

  // One in-flight writer; an invalid slot is kept all-zero so published fields read 0.
  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               is_load;
  } slot_t;

  function automatic logic is_load_id(input logic [INSTR_ID_W-1:0] iid);
    case (iid)
      ID_LB, ID_LH, ID_LW, ID_LBU, ID_LHU: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// EX/MEM/WB writer shadow slots; advance one stage per clock, 1-cycle latency.
// Holds everything while mem_wait (flush still clears EX); flush or load-use inserts an EX bubble.
module hazard_slot_pipe
  import hazard_scoreboard_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_use,
  input  logic  flush,
  input  logic  mem_wait,
  input  slot_t id_slot,
  output slot_t ex_slot,
  output slot_t mem_slot,
  output slot_t wb_slot
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
    end else if (mem_wait) begin
      // Frozen pipeline: a redirect still kills the squashed EX instruction.
      if (flush) begin
        ex_slot <= '0;
      end
    end else if (flush || load_use) begin
      ex_slot  <= '0;
      mem_slot <= ex_slot;
      wb_slot  <= mem_slot;
    end else begin
      ex_slot  <= id_slot;
      mem_slot <= ex_slot;
      wb_slot  <= mem_slot;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard detect plus MEM/WB writer publish; stall/bubble are combinational, slots 1-cycle.
// mem_wait freezes slots and holds ID; optional counters under HAZARD_STATS_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int ID_W   = 6
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_valid,
  input  logic              id_rs2_valid,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_rd_valid,
  input  logic [ID_W-1:0]   id_instr_id,
  input  logic              flush,
  input  logic              mem_wait,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic [REG_AW-1:0] rd_addr_mem,
  output logic              rd_valid_mem,
  output logic              is_load_mem,
  output logic [REG_AW-1:0] rd_addr_wb,
  output logic              rd_valid_wb
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stat_lu_stalls,
  output logic [31:0]       stat_mw_cycles
`endif
);

  slot_t id_slot;
  slot_t ex_slot;
  slot_t mem_slot;
  slot_t wb_slot;
  logic  rs1_hit;
  logic  rs2_hit;
  logic  lu_hit;
  logic  lu_stall;

  // x0 writes are never tracked, so they can never raise a hazard.
  always_comb begin
    id_slot = '0;
    if (id_valid && id_rd_valid && (id_rd_addr != '0)) begin
      id_slot.valid   = 1'b1;
      id_slot.rd      = id_rd_addr;
      id_slot.is_load = is_load_id(id_instr_id);
    end
  end

  assign rs1_hit  = id_rs1_valid && (id_rs1_addr == ex_slot.rd);
  assign rs2_hit  = id_rs2_valid && (id_rs2_addr == ex_slot.rd);
  assign lu_hit   = id_valid && ex_slot.valid && ex_slot.is_load && (rs1_hit || rs2_hit);
  assign lu_stall = lu_hit && !flush && !mem_wait;

  // A flushed ID instruction is discarded, so it must not hold the front end.
  assign stall_id  = !rst && (mem_wait || (lu_hit && !flush));
  assign bubble_ex = !rst && lu_stall;

  hazard_slot_pipe u_slot_pipe (
    .clk      (clk),
    .rst      (rst),
    .load_use (lu_hit),
    .flush    (flush),
    .mem_wait (mem_wait),
    .id_slot  (id_slot),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .wb_slot  (wb_slot)
  );

  assign rd_addr_mem  = mem_slot.rd;
  assign rd_valid_mem = mem_slot.valid;
  assign is_load_mem  = mem_slot.is_load;
  assign rd_addr_wb   = wb_slot.rd;
  assign rd_valid_wb  = wb_slot.valid;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lu_stalls <= '0;
      stat_mw_cycles <= '0;
    end else begin
      if (lu_stall && (stat_lu_stalls != 32'hFFFF_FFFF)) begin
        stat_lu_stalls <= stat_lu_stalls + 32'd1;
      end
      if (mem_wait && (stat_mw_cycles != 32'hFFFF_FFFF)) begin
        stat_mw_cycles <= stat_mw_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Producer-side companion to operand forwarding. It tracks the destination registers of in-flight instructions in the EX, MEM and WB shadow slots and publishes the MEM/WB writer information that forwarding consumes. It detects load-use hazards for the instruction in ID and issues the stall and bubble controls. It sits between the decode stage and the EX/MEM/WB pipeline registers of the 5-stage core.

## Interface
Parameters:
- `REG_AW`, 5: register address width.
- `ID_W`, 6: instruction-ID width, matching the instruction-ID constants.

Ports:
- `clk`  in  1  core clock. One clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1_addr`, `id_rs2_addr`  in  REG_AW  ID source registers.
- `id_rs1_valid`, `id_rs2_valid`  in  1  source is actually read.
- `id_rd_addr`  in  REG_AW  ID destination.
- `id_rd_valid`  in  1  ID instruction writes rd.
- `id_instr_id`  in  ID_W  ID instruction ID. Load IDs mark the slot as a load.
- `flush`  in  1  branch/jump redirect. Squashes ID and EX.
- `mem_wait`  in  1  data memory not ready. Freezes the pipeline.
- `stall_id`  out  1  hold PC and IF/ID.
- `bubble_ex`  out  1  load NOP into ID/EX.
- `rd_addr_mem`, `rd_valid_mem`, `is_load_mem`  out  REG_AW/1/1  MEM-slot writer.
- `rd_addr_wb`, `rd_valid_wb`  out  REG_AW/1  WB-slot writer.
- `stat_lu_stalls`, `stat_mw_cycles`  out  32  only present with `HAZARD_STATS_EN`.

## Operation
- Three slots: EX, MEM, WB. Each slot holds {valid, rd, is_load}.
- A slot is marked valid only when the instruction writes rd and `rd != 0`. Writes to x0 are never tracked.
- Load-use hazard condition: `id_valid`, and the EX slot is a valid load, and (`id_rs1_valid` with `id_rs1_addr == ex.rd`, or `id_rs2_valid` with `id_rs2_addr == ex.rd`).
- On a load-use hazard, `stall_id` = 1 and `bubble_ex` = 1.
- Non-load producers never stall. Results from MEM and WB are forwarded.
- Slot advance at each clock edge, evaluated in priority order:
  - **Freeze:** when `mem_wait` = 1, all slots hold. The only exception: if `flush` = 1, the EX slot is cleared.
  - **Flush:** when `flush` = 1 (and not frozen), EX takes a bubble, MEM takes EX, WB takes MEM. `stall_id` and `bubble_ex` are forced to 0 that cycle, because the ID instruction is discarded.
  - **Load-use:** EX takes a bubble, MEM takes EX, WB takes MEM.
  - **Normal:** EX takes the ID instruction (valid only if `id_valid`), MEM takes EX, WB takes MEM.
- While `mem_wait` = 1, `stall_id` = 1 so IF/ID holds. `bubble_ex` = 0.
- Published outputs are taken directly from the MEM and WB slots.
- Reset clears all slots to invalid. All outputs go to 0 and the counters clear to 0.
- If `rst` is asserted mid-stall, state clears immediately. The first cycle after deassertion is normal.

## Timing
- `stall_id` and `bubble_ex` are combinational from the ID inputs and the EX slot, in the same cycle as the hazard.
- Slot and published outputs update at the clock edge, one cycle after their inputs.
- A load-use hazard costs exactly 1 stall cycle. In the next cycle the load sits in MEM, so the hazard is clear and forwarding from MEM supplies the data.
- `mem_wait` held for N cycles extends any stall by exactly N cycles. The load-use condition is re-evaluated after `mem_wait` drops.
- Back-to-back load-use pairs each take 1 cycle. Stalls do not accumulate.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stat_lu_stalls` increments on each cycle with a load-use stall that is neither flushed nor frozen.
  - `stat_mw_cycles` increments on each cycle with `mem_wait` = 1.
  - Both are 32-bit, saturate at 0xFFFF_FFFF, and clear on `rst`.
- `HAZARD_STATS_EN` undefined: the counter ports and logic are absent. All other behaviour is identical.

## Structure
- Add the slot field layout and the load-ID set to the shared instruction-defines header, next to the existing instruction-ID constants. Load IDs: LB, LH, LW, LBU, LHU.
- Sub-module `hazard_slot_pipe` holds the three slot registers and the advance/freeze/flush muxing.
- The top level keeps the hazard comparator, the output decode and the optional counters.

## Test plan
- LW x5 followed immediately by ADD x6,x5,x1 → `stall_id` = `bubble_ex` = 1 for exactly 1 cycle. Next cycle: `rd_addr_mem` = 5, `is_load_mem` = 1, no stall.
- ADD x5 followed by SUB x7,x5,x5 → never stalls. One cycle later `rd_valid_mem` = 1 with `rd_addr_mem` = 5. After another cycle the same information moves to the WB outputs.
- LW x0 followed by use of x0 → no stall. `rd_valid_mem` stays 0.
- LW x5 in EX, use of x5 in ID, `mem_wait` held 3 cycles → stall lasts 3 cycles. Slots frozen. Then exactly 1 load-use bubble.
- Load-use hazard with `flush` = 1 in the same cycle → `stall_id` = 0. EX slot becomes invalid next cycle. The load moves to MEM.
- `rst` pulse mid-stall → all outputs 0 asynchronously. With `HAZARD_STATS_EN`, both counters read 0.
